// File: rtl/mesh_core_ctrl_responder.sv
// Core-side mesh management responder: executes held-bus commands on change and
// round-robin arbitrates core report words onto one channel. Build macro CMD_ERR_STATUS_EN adds err_count.
module mesh_core_ctrl_responder #(
    parameter int NUM_CORES  = 16,
    parameter int ID_BITS    = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                            clock,
    input  logic                            RST,
    input  logic [3:0]                      operation,
    input  logic [ID_BITS-1:0]              core_ID,
    input  logic                            ON,
    input  logic                            reset_in,
    input  logic                            start,
    input  logic [ADDR_WIDTH-1:0]           prog_address,
    output logic [NUM_CORES-1:0]            core_on,
    output logic [NUM_CORES-1:0]            core_reset,
    output logic [NUM_CORES-1:0]            core_start,
    output logic [NUM_CORES*ADDR_WIDTH-1:0] core_boot_addr,
    input  logic [NUM_CORES-1:0]            core_out_valid,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] core_out_data,
    output logic [NUM_CORES-1:0]            core_out_ack,
    input  logic                            out_ready,
    output logic [ID_BITS-1:0]              origin,
    output logic [DATA_WIDTH-1:0]           data_out,
    output logic                            valid_out
`ifdef CMD_ERR_STATUS_EN
    ,
    output logic [7:0]                      err_count
`endif
);

    localparam logic [3:0] OP_NOP    = 4'b0000;
    localparam logic [3:0] OP_CONFIG = 4'b0011;
    localparam logic [3:0] OP_BOOT   = 4'b1010;
    localparam int         CMD_W     = 4 + ID_BITS + 3 + ADDR_WIDTH;

    logic [NUM_CORES-1:0]            core_on_q, core_on_d;
    logic [NUM_CORES-1:0]            core_reset_q, core_reset_d;
    logic [NUM_CORES-1:0]            core_start_q, core_start_d;
    logic [NUM_CORES*ADDR_WIDTH-1:0] boot_addr_q, boot_addr_d;
    logic [CMD_W-1:0]                cmd_prev_q, cmd_prev_d;
    logic                            cmd_first_q, cmd_first_d;
    logic [NUM_CORES-1:0]            ack_q, ack_d;
    logic [ID_BITS-1:0]              origin_q, origin_d;
    logic [DATA_WIDTH-1:0]           data_q, data_d;
    logic                            valid_q, valid_d;
    logic [ID_BITS-1:0]              rr_q, rr_d;

    logic                            cmd_new;
    logic                            err_inc;
    logic [NUM_CORES-1:0]            eligible;
    logic                            grant_found;
    logic [ID_BITS-1:0]              grant_idx;
    logic                            take;
    int                              cand;

    // The sequencer holds its bus level, so only a changed (or first) word is a command.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        cmd_prev_d   = {operation, core_ID, ON, reset_in, start, prog_address};
        cmd_first_d  = 1'b0;
        cmd_new      = cmd_first_q || (cmd_prev_d != cmd_prev_q);
        core_on_d    = core_on_q;
        core_reset_d = core_reset_q;
        core_start_d = '0;
        boot_addr_d  = boot_addr_q;
        err_inc      = 1'b0;
        if (cmd_new) begin
            case (operation)
                OP_NOP: ;
                OP_CONFIG: begin
                    core_on_d[core_ID]    = ON;
                    core_reset_d[core_ID] = reset_in;
                end
                OP_BOOT: begin
                    boot_addr_d[int'(core_ID)*ADDR_WIDTH +: ADDR_WIDTH] = prog_address;
                    if (core_on_q[core_ID]) begin
                        core_reset_d[core_ID] = 1'b0;
                        core_start_d[core_ID] = start;
                    end else begin
                        err_inc = start;
                    end
                end
                default: err_inc = 1'b1;
            endcase
        end
    end

    // A core whose ack is high this cycle is still showing the word just taken.
    always_comb begin
        eligible    = core_out_valid & ~ack_q;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = (int'(rr_q) + k) % NUM_CORES;
            if (!grant_found && eligible[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_BITS'(cand);
            end
        end
        take     = out_ready && grant_found;
        valid_d  = take;
        origin_d = take ? grant_idx : '0;
        data_d   = take ? core_out_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH] : '0;
        ack_d    = '0;
        if (take) begin
            ack_d[grant_idx] = 1'b1;
        end
        rr_d = take ? grant_idx : rr_q;
    end

    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!RST) begin
            core_on_q    <= '0;
            core_reset_q <= '0;
            core_start_q <= '0;
            // NOTE: the boot-address bank is a visible output with a defined reset value, so it is reset too.
            boot_addr_q  <= '0;
            cmd_prev_q   <= '0;
            cmd_first_q  <= 1'b1;
            ack_q        <= '0;
            origin_q     <= '0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            rr_q         <= ID_BITS'(NUM_CORES - 1);
        end else begin
            core_on_q    <= core_on_d;
            core_reset_q <= core_reset_d;
            core_start_q <= core_start_d;
            boot_addr_q  <= boot_addr_d;
            cmd_prev_q   <= cmd_prev_d;
            cmd_first_q  <= cmd_first_d;
            ack_q        <= ack_d;
            origin_q     <= origin_d;
            data_q       <= data_d;
            valid_q      <= valid_d;
            rr_q         <= rr_d;
        end
    end

`ifdef CMD_ERR_STATUS_EN
    logic [7:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (err_inc && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (!RST) begin
            err_q <= '0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_count = err_q;
`else
    logic unused_err_inc;
    assign unused_err_inc = err_inc;
`endif

    assign core_on        = core_on_q;
    assign core_reset     = core_reset_q;
    assign core_start     = core_start_q;
    assign core_boot_addr = boot_addr_q;
    assign core_out_ack   = ack_q;
    assign origin         = origin_q;
    assign data_out       = data_q;
    assign valid_out      = valid_q;

endmodule

// File: tb/tb_mesh_core_ctrl_responder.sv
// Self-checking bench for mesh_core_ctrl_responder: a behavioural reference model is
// compared against the DUT every cycle, plus directed literal checks from the test plan.
module tb_mesh_core_ctrl_responder;

    localparam int N   = 16;
    localparam int IDB = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int CW  = 4 + IDB + 3 + AW;

    logic            clock = 1'b0;
    logic            RST;
    logic [3:0]      operation;
    logic [IDB-1:0]  core_ID;
    logic            ON, reset_in, start;
    logic [AW-1:0]   prog_address;
    logic [N-1:0]    core_on, core_reset, core_start, core_out_ack, core_out_valid;
    logic [N*AW-1:0] core_boot_addr;
    logic [N*DW-1:0] core_out_data;
    logic            out_ready;
    logic [IDB-1:0]  origin;
    logic [DW-1:0]   data_out;
    logic            valid_out;
`ifdef CMD_ERR_STATUS_EN
    logic [7:0]      err_count;
`endif

    always #5 clock = ~clock;

    mesh_core_ctrl_responder #(
        .NUM_CORES(N), .ID_BITS(IDB), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
    ) dut (
        .clock(clock), .RST(RST), .operation(operation), .core_ID(core_ID),
        .ON(ON), .reset_in(reset_in), .start(start), .prog_address(prog_address),
        .core_on(core_on), .core_reset(core_reset), .core_start(core_start),
        .core_boot_addr(core_boot_addr), .core_out_valid(core_out_valid),
        .core_out_data(core_out_data), .core_out_ack(core_out_ack),
        .out_ready(out_ready), .origin(origin), .data_out(data_out), .valid_out(valid_out)
`ifdef CMD_ERR_STATUS_EN
        , .err_count(err_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    task automatic check_wide(input string name, input logic [N*AW-1:0] act, input logic [N*AW-1:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    // Reference model state, in plain per-core arrays and integers.
    logic [N-1:0]  m_on, m_rst, m_start, m_ack;
    logic [AW-1:0] m_addr [N];
    logic          m_valid;
    int            m_origin;
    logic [DW-1:0] m_data;
    int            m_rr;
    logic [CW-1:0] m_prev;
    bit            m_first;
    int            m_err;
    bit            model_live = 1'b0;

    task automatic model_step();
        logic [CW-1:0] cmd;
        logic [N-1:0]  elig;
        int            win;
        cmd = {operation, core_ID, ON, reset_in, start, prog_address};
        if (!RST) begin
            m_on = '0; m_rst = '0; m_start = '0; m_ack = '0;
            m_valid = 1'b0; m_origin = 0; m_data = '0;
            for (int i = 0; i < N; i++) m_addr[i] = '0;
            m_rr = N - 1; m_prev = '0; m_first = 1'b1; m_err = 0;
            model_live = 1'b1;
            return;
        end
        m_start = '0;
        if (m_first || cmd != m_prev) begin
            if (operation == 4'b0011) begin
                m_on[core_ID]  = ON;
                m_rst[core_ID] = reset_in;
            end else if (operation == 4'b1010) begin
                m_addr[core_ID] = prog_address;
                if (m_on[core_ID]) begin
                    m_rst[core_ID]   = 1'b0;
                    m_start[core_ID] = start;
                end else if (start) begin
                    m_err = (m_err < 255) ? m_err + 1 : 255;
                end
            end else if (operation != 4'b0000) begin
                m_err = (m_err < 255) ? m_err + 1 : 255;
            end
        end
        m_prev  = cmd;
        m_first = 1'b0;
        elig = core_out_valid & ~m_ack;
        win  = -1;
        if (out_ready) begin
            for (int k = 1; k <= N; k++) begin
                if (win < 0 && elig[(m_rr + k) % N]) win = (m_rr + k) % N;
            end
        end
        m_ack = '0;
        if (win >= 0) begin
            m_valid = 1'b1; m_origin = win; m_data = core_out_data[win*DW +: DW];
            m_ack[win] = 1'b1; m_rr = win;
        end else begin
            m_valid = 1'b0; m_origin = 0; m_data = '0;
        end
    endtask

    // Observation logs used by the directed checks.
    int            origin_log [$];
    int            start_cnt  [N];
    int            ack_cnt    [N];
    logic [N-1:0]  retire_mask = '0;
    logic [N*AW-1:0] exp_addr;

    always @(negedge clock) begin
        if (model_live) begin
            for (int i = 0; i < N; i++) exp_addr[i*AW +: AW] = m_addr[i];
            check("core_on", core_on, m_on);
            check("core_reset", core_reset, m_rst);
            check("core_start", core_start, m_start);
            check_wide("core_boot_addr", core_boot_addr, exp_addr);
            check("core_out_ack", core_out_ack, m_ack);
            check("valid_out", valid_out, m_valid);
            check("origin", origin, m_origin);
            check("data_out", data_out, m_data);
`ifdef CMD_ERR_STATUS_EN
            check("err_count", err_count, m_err);
`endif
            if (valid_out) origin_log.push_back(int'(origin));
            for (int i = 0; i < N; i++) begin
                start_cnt[i] += int'(core_start[i]);
                ack_cnt[i]   += int'(core_out_ack[i]);
            end
        end
        retire_mask = model_live ? m_ack : '0;
        model_step();
    end

    // Core-side word sources: core i presents word nxt[i] while rem[i] words remain.
    int          rem [N];
    int          nxt [N];
    logic [15:0] salt;

    task automatic drive_cores();
        for (int i = 0; i < N; i++) begin
            core_out_valid[i] = (rem[i] > 0);
            core_out_data[i*DW +: DW] = {8'(i), 8'(nxt[i]), salt};
        end
    endtask

    task automatic set_words(input int core, input int count);
        rem[core] = count;
        drive_cores();
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        for (int i = 0; i < N; i++) begin
            if (retire_mask[i] && rem[i] > 0) begin
                rem[i]--;
                nxt[i]++;
            end
        end
        drive_cores();
    endtask

    task automatic set_cmd(input logic [3:0] op, input int id, input logic on_v,
                           input logic rin, input logic st, input logic [AW-1:0] pa);
        operation = op; core_ID = IDB'(id); ON = on_v; reset_in = rin; start = st; prog_address = pa;
    endtask

    task automatic clear_logs();
        origin_log.delete();
        for (int i = 0; i < N; i++) begin
            start_cnt[i] = 0;
            ack_cnt[i]   = 0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int total_starts;
        logic [3:0] rop;
        bit all_empty;
        RST = 1'b0;
        out_ready = 1'b0;
        salt = 16'($urandom);
        for (int i = 0; i < N; i++) begin rem[i] = 0; nxt[i] = 0; end
        drive_cores();
        set_cmd(4'b0000, 0, 1'b0, 1'b0, 1'b0, '0);
        repeat (3) tick();
        RST = 1'b1;
        tick();
        check("reset_valid_out", valid_out, 1'b0);
        check("reset_core_on", core_on, 16'h0000);

        // Power up every core, held in reset.
        clear_logs();
        for (int id = 0; id < N; id++) begin
            set_cmd(4'b0011, id, 1'b1, 1'b1, 1'b0, '0);
            tick();
        end
        set_cmd(4'b0000, 0, 1'b0, 1'b0, 1'b0, '0);
        tick();
        total_starts = 0;
        for (int i = 0; i < N; i++) total_starts += start_cnt[i];
        check("config_all_on", core_on, 16'hFFFF);
        check("config_all_reset", core_reset, 16'hFFFF);
        check("config_no_start", total_starts, 0);

        // BOOT core 3, bus held for 5 cycles: a single start pulse.
        clear_logs();
        set_cmd(4'b1010, 3, 1'b0, 1'b0, 1'b1, 32'h30010);
        repeat (5) tick();
        set_cmd(4'b0000, 0, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) tick();
        check("boot3_one_pulse", start_cnt[3], 1);
        check("boot3_addr", core_boot_addr[3*AW +: AW], 32'h30010);
        check("boot3_reset_cleared", core_reset[3], 1'b0);

        // BOOT to a powered-off core is rejected but latches the address.
        clear_logs();
        set_cmd(4'b0011, 5, 1'b0, 1'b1, 1'b0, '0);
        tick();
        set_cmd(4'b1010, 5, 1'b0, 1'b0, 1'b1, 32'h50050);
        repeat (2) tick();
        check("boot5_no_pulse", start_cnt[5], 0);
        check("boot5_addr", core_boot_addr[5*AW +: AW], 32'h50050);
        check("boot5_reset_kept", core_reset[5], 1'b1);
`ifdef CMD_ERR_STATUS_EN
        check("err_after_reject", err_count, 8'd1);
`endif
        set_cmd(4'b1111, 0, 1'b0, 1'b0, 1'b0, '0);
        repeat (2) tick();
`ifdef CMD_ERR_STATUS_EN
        check("err_after_illegal", err_count, 8'd2);
`endif
        set_cmd(4'b0000, 0, 1'b0, 1'b0, 1'b0, '0);
        tick();

        // Three requesters, FIFO ready: back-to-back grants 2, 7, 9.
        clear_logs();
        out_ready = 1'b1;
        set_words(2, 1); set_words(7, 1); set_words(9, 1);
        repeat (6) tick();
        check("rr_count", origin_log.size(), 3);
        if (origin_log.size() == 3) begin
            check("rr_first", origin_log[0], 2);
            check("rr_second", origin_log[1], 7);
            check("rr_third", origin_log[2], 9);
        end
        check("ack2_once", ack_cnt[2], 1);
        check("ack7_once", ack_cnt[7], 1);
        check("ack9_once", ack_cnt[9], 1);

        // Backpressure for 4 cycles, then release: first grant wraps to core 2.
        clear_logs();
        out_ready = 1'b0;
        set_words(2, 1); set_words(7, 1); set_words(9, 1);
        repeat (4) tick();
        check("bp_no_grants", origin_log.size(), 0);
        check("bp_no_acks", ack_cnt[2] + ack_cnt[7] + ack_cnt[9], 0);
        out_ready = 1'b1;
        repeat (5) tick();
        check("bp_release_count", origin_log.size(), 3);
        if (origin_log.size() > 0) check("bp_release_first", origin_log[0], 2);

        // Randomised commands, report traffic and backpressure.
        for (int cyc = 0; cyc < 400; ) begin
            int r;
            int hold;
            r = int'($urandom_range(0, 9));
            if (r < 3) rop = 4'b0000;
            else if (r < 6) rop = 4'b0011;
            else if (r < 9) rop = 4'b1010;
            else begin
                rop = 4'($urandom);
                if (rop == 4'b0000 || rop == 4'b0011 || rop == 4'b1010) rop = 4'b1111;
            end
            set_cmd(rop, int'($urandom_range(0, N-1)), 1'($urandom), 1'($urandom),
                    1'($urandom), $urandom);
            hold = int'($urandom_range(1, 3));
            for (int h = 0; h < hold; h++) begin
                out_ready = ($urandom_range(0, 3) != 0);
                for (int i = 0; i < N; i++) begin
                    if (rem[i] == 0 && $urandom_range(0, 7) == 0) rem[i] = int'($urandom_range(1, 4));
                end
                drive_cores();
                tick();
                cyc++;
            end
        end

        // Drain all report words before the reset scenario.
        set_cmd(4'b0000, 0, 1'b0, 1'b0, 1'b0, '0);
        out_ready = 1'b1;
        all_empty = 1'b0;
        for (int t = 0; t < 200 && !all_empty; t++) begin
            tick();
            all_empty = 1'b1;
            for (int i = 0; i < N; i++) if (rem[i] != 0) all_empty = 1'b0;
        end
        check("drain_done", all_empty, 1'b1);
        repeat (2) tick();

        // Reset in the middle of a burst from core 7; the word is re-presented afterwards.
        set_words(7, 6);
        repeat (3) tick();
        RST = 1'b0;
        tick();
        check("midrst_valid_out", valid_out, 1'b0);
        check("midrst_ack", core_out_ack, 16'h0000);
        check("midrst_core_on", core_on, 16'h0000);
        check("midrst_data_out", data_out, 32'h0);
        RST = 1'b1;
        clear_logs();
        repeat (4) tick();
        check("midrst_regrant_seen", origin_log.size() > 0, 1'b1);
        if (origin_log.size() > 0) check("midrst_regrant_origin", origin_log[0], 7);
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
